// File: rtl/pa_f_spsram_ctrl.sv
// pa_f_spsram_ctrl: request-side controller for a single-port SRAM macro.
// It fills the array with INIT_VALUE after reset, then serves in-order
// single-beat reads/writes. Read data returns through a 2-entry response
// buffer with bypass.
module pa_f_spsram_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic                    rd_inflight;
  logic [DATA_WIDTH-1:0]   buf_mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              buf_count;
  logic [ADDR_WIDTH-1:0]   last_a;
  logic [DATA_WIDTH-1:0]   last_d;

  logic [1:0]              occupancy;
  logic                    acc;
  logic                    acc_rd;
  logic                    acc_wr;
  logic                    buf_nonempty;
  logic                    push;
  logic                    pop;

  // Request acceptance: room for every read that is buffered or in flight
  always_comb begin
    occupancy = buf_count + {1'b0, rd_inflight};
    req_rdy   = !RST && (state == ST_IDLE) && (occupancy < 2'd2);
    acc       = req_vld && req_rdy;
    acc_rd    = acc && !req_wr;
    acc_wr    = acc && req_wr && (|req_wmask);
    init_busy = RST || (state == ST_INIT);
  end

  // SRAM pin drive: sampled by the macro on the same edge as the accept
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = last_a;
    sram_d    = last_d;
    if (RST) begin
      sram_a = '0;
      sram_d = '0;
    end else if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
      sram_d    = INIT_VALUE;
    end else if (acc_rd) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
    end else if (acc_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end
  end

  // Response path: bypass sram_q when the buffer is empty, else present the head
  always_comb begin
    buf_nonempty = (buf_count != 2'd0);
    push         = rd_inflight && (buf_nonempty || !rsp_rdy);
    pop          = buf_nonempty && rsp_rdy;
    rsp_vld      = !RST && (buf_nonempty || rd_inflight);
    rsp_rdata    = '0;
    if (!RST) begin
      if (buf_nonempty) begin
        rsp_rdata = buf_mem[rd_ptr];
      end else if (rd_inflight) begin
        rsp_rdata = sram_q;
      end
    end
  end

  // Control FSM: walk the array once, then serve requests
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= acc_rd;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (init_cnt == LAST_ADDR) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response FIFO storage and pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= sram_q;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Address/data hold so idle cycles keep the pins stable
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_a <= '0;
      last_d <= '0;
    end else begin
      last_a <= sram_a;
      last_d <= sram_d;
    end
  end

endmodule

// File: tb/tb_pa_f_spsram_ctrl.sv
// Testbench for pa_f_spsram_ctrl with a behavioural 256x32 SRAM model and
// a response scoreboard.
module tb_pa_f_spsram_ctrl;

  logic        clk;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_wmask;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        init_busy;
  logic [7:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  int checks;
  int errors;
  int cyc;
  logic [31:0] exp_q [$];

  pa_f_spsram_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .init_busy (init_busy),
    .sram_a    (sram_a),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // SRAM model: pre-filled with junk so the init walk is observable
  logic [31:0] mem [256];
  bit          mem_filled;
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
      mem_filled <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered response must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF ^ rsp_rdata);
        else                   chk("rsp_data", rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; call right after a posedge. Returns after the accept edge.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] wmask, input logic [31:0] exp, input bit track);
    int n;
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_rdy) chk("req_accept_timeout", 32'(req_rdy), 32'd1);
    else if (!wr && track) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    sync();
  endtask

  // Follow the init walk from cycle 0 through the first IDLE cycle
  task automatic init_walk();
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      chk("init_a", 32'(sram_a), 32'(k));
      chk("init_cen", 32'(sram_cen), 32'd0);
      chk("init_gwen", 32'(sram_gwen), 32'd0);
      chk("init_wen", sram_wen, 32'd0);
      chk("init_d", sram_d, 32'd0);
      chk("init_busy", 32'(init_busy), 32'd1);
      chk("init_rdy", 32'(req_rdy), 32'd0);
      chk("init_rsp_vld", 32'(rsp_vld), 32'd0);
    end
    @(negedge clk);
    chk("idle_busy", 32'(init_busy), 32'd0);
    chk("idle_rdy", 32'(req_rdy), 32'd1);
    chk("idle_cen", 32'(sram_cen), 32'd1);
    sync();
  endtask

  initial begin
    int c0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_vld   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    req_wmask = 32'h0;
    rsp_rdy   = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_gwen", 32'(sram_gwen), 32'd1);
    chk("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_d", sram_d, 32'd0);
    sync();
    rst = 1'b0;
    init_walk();

    // Initialised entries read back as INIT_VALUE
    issue(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 8'h7F, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 8'hFF, 32'h0, 32'h0, 32'h0, 1'b1);
    drain();

    // Full write, masked write, read with one-cycle latency
    issue(1'b1, 8'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(1'b1, 8'h10, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 1'b0);
    issue(1'b0, 8'h10, 32'h0, 32'h0, 32'hDEAD_5678, 1'b1);
    @(negedge clk);
    chk("lat_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("lat_rsp_rdata", rsp_rdata, 32'hDEAD_5678);
    drain();

    // Back-to-back reads at full throughput
    for (int i = 1; i <= 8; i++) issue(1'b1, 8'(i), 32'(i), 32'hFFFF_FFFF, 32'h0, 1'b0);
    c0 = cyc;
    for (int i = 1; i <= 8; i++) issue(1'b0, 8'(i), 32'h0, 32'h0, 32'(i), 1'b1);
    chk("b2b_cycles", 32'(cyc - c0), 32'd8);
    drain();

    // Back-pressure: only two reads outstanding
    rsp_rdy = 1'b0;
    issue(1'b0, 8'h01, 32'h0, 32'h0, 32'd1, 1'b1);
    issue(1'b0, 8'h02, 32'h0, 32'h0, 32'd2, 1'b1);
    req_vld  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_rdy", 32'(req_rdy), 32'd0);
      chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("bp_rsp_head", rsp_rdata, 32'd1);
    end
    sync();
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rdy_still_low", 32'(req_rdy), 32'd0);
    @(negedge clk);
    chk("bp_rdy_after_pop", 32'(req_rdy), 32'd1);
    if (req_rdy) exp_q.push_back(32'd3);
    sync();
    req_vld = 1'b0;
    drain();

    // Write with empty mask: consumed, no SRAM access
    req_vld   = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 8'h05;
    req_wdata = 32'hFFFF_FFFF;
    req_wmask = 32'h0;
    @(negedge clk);
    chk("wm0_rdy", 32'(req_rdy), 32'd1);
    chk("wm0_cen", 32'(sram_cen), 32'd1);
    sync();
    req_vld = 1'b0;
    issue(1'b0, 8'h05, 32'h0, 32'h0, 32'd5, 1'b1);
    drain();

    // Reset with two responses buffered: nothing stale comes out
    rsp_rdy = 1'b0;
    issue(1'b0, 8'h01, 32'h0, 32'h0, 32'd1, 1'b0);
    issue(1'b0, 8'h02, 32'h0, 32'h0, 32'd2, 1'b0);
    sync();
    @(negedge clk);
    chk("pre_rst_rsp_vld", 32'(rsp_vld), 32'd1);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("mid_rst_busy", 32'(init_busy), 32'd1);
    sync();
    rst     = 1'b0;
    rsp_rdy = 1'b1;
    init_walk();
    issue(1'b0, 8'h10, 32'h0, 32'h0, 32'h0, 1'b1);
    drain();
    repeat (4) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
